// File: rtl/bcd_to_bin_field.sv
// bcd_to_bin_field: sequential packed-BCD to binary converter for clock/calendar
// set-mode entry. Processes one digit per cycle, most significant first, then
// holds the result with digit-error and [lo, hi] range flags until consumed.
module bcd_to_bin_field #(
   parameter int DIGITS = 4,
   parameter int BIN_W  = 14
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [4*DIGITS-1:0]   bcd,
   input  logic [BIN_W-1:0]      lo,
   input  logic [BIN_W-1:0]      hi,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [BIN_W-1:0]      bin,
   output logic                  err_digit,
   output logic                  err_range
);

   localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
   localparam logic [IDX_W-1:0] IDX_TOP = IDX_W'(DIGITS - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CONV = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t              state_q, state_d;
   logic [BIN_W-1:0]    acc_q, acc_d;
   logic [IDX_W-1:0]    idx_q, idx_d;
   logic [4*DIGITS-1:0] bcd_q, bcd_d;
   logic [BIN_W-1:0]    lo_q, lo_d;
   logic [BIN_W-1:0]    hi_q, hi_d;
   logic                bad_q, bad_d;
   logic [BIN_W-1:0]    bin_q, bin_d;
   logic                err_digit_q, err_digit_d;
   logic                err_range_q, err_range_d;

   // Per-nibble views: illegal-digit detect on the incoming field, and the
   // latched digits for the conversion mux.
   logic [DIGITS-1:0]   nib_bad;
   logic [3:0]          digit_arr [DIGITS];
   logic [3:0]          cur_digit;
   logic [BIN_W-1:0]    acc_step;

   genvar gi;
   generate
      for (gi = 0; gi < DIGITS; gi++) begin : g_nib
         assign nib_bad[gi]   = (bcd[gi*4 +: 4] > 4'd9);
         assign digit_arr[gi] = bcd_q[gi*4 +: 4];
      end
   endgenerate

   assign cur_digit = digit_arr[idx_q];

   // acc*10 + digit as (acc<<3)+(acc<<1)+digit. Only the low BIN_W bits are
   // kept; the carries above them never influence the low bits, so computing
   // at BIN_W is identical to truncating a wider sum, and is lossless whenever
   // the input is legal BCD.
   assign acc_step = (acc_q << 3) + (acc_q << 1) + BIN_W'(cur_digit);

   // Next-state and datapath: accept in IDLE, one digit per cycle in CONV,
   // publish result on the last digit, wait for the consumer in DONE.
   always_comb begin
      state_d     = state_q;
      acc_d       = acc_q;
      idx_d       = idx_q;
      bcd_d       = bcd_q;
      lo_d        = lo_q;
      hi_d        = hi_q;
      bad_d       = bad_q;
      bin_d       = bin_q;
      err_digit_d = err_digit_q;
      err_range_d = err_range_q;
      case (state_q)
         IDLE: begin
            if (in_valid) begin
               bcd_d   = bcd;
               lo_d    = lo;
               hi_d    = hi;
               bad_d   = |nib_bad;
               acc_d   = '0;
               idx_d   = IDX_TOP;
               state_d = CONV;
            end
         end
         CONV: begin
            acc_d = acc_step;
            if (idx_q == '0) begin
               // Illegal digits still take the full DIGITS cycles so timing
               // never depends on data; the result is then forced to zero.
               state_d     = DONE;
               err_digit_d = bad_q;
               bin_d       = bad_q ? '0 : acc_step;
               err_range_d = bad_q ? 1'b0 : ((acc_step < lo_q) | (acc_step > hi_q));
            end else begin
               idx_d = idx_q - IDX_W'(1);
            end
         end
         DONE: begin
            if (out_ready) begin
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State and datapath registers; reset abandons any request in flight.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         acc_q       <= '0;
         idx_q       <= '0;
         bcd_q       <= '0;
         lo_q        <= '0;
         hi_q        <= '0;
         bad_q       <= 1'b0;
         bin_q       <= '0;
         err_digit_q <= 1'b0;
         err_range_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         acc_q       <= acc_d;
         idx_q       <= idx_d;
         bcd_q       <= bcd_d;
         lo_q        <= lo_d;
         hi_q        <= hi_d;
         bad_q       <= bad_d;
         bin_q       <= bin_d;
         err_digit_q <= err_digit_d;
         err_range_q <= err_range_d;
      end
   end

   assign in_ready  = (state_q == IDLE);
   assign out_valid = (state_q == DONE);
   assign bin       = bin_q;
   assign err_digit = err_digit_q;
   assign err_range = err_range_q;

endmodule

// File: tb/tb_bcd_to_bin_field.sv
// Testbench for bcd_to_bin_field: directed calendar cases, back-pressure,
// mid-conversion reset, back-to-back streaming and randomized requests,
// checked against an arithmetic reference model.
module tb_bcd_to_bin_field;

   localparam int DIGITS = 4;
   localparam int BIN_W  = 14;

   logic              clk = 1'b0;
   logic              rst_n;
   logic              in_valid;
   logic              in_ready;
   logic [15:0]       bcd;
   logic [BIN_W-1:0]  lo;
   logic [BIN_W-1:0]  hi;
   logic              out_valid;
   logic              out_ready;
   logic [BIN_W-1:0]  bin;
   logic              err_digit;
   logic              err_range;

   int n_cmp  = 0;
   int n_fail = 0;

   bcd_to_bin_field #(.DIGITS(DIGITS), .BIN_W(BIN_W)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .bcd       (bcd),
      .lo        (lo),
      .hi        (hi),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .bin       (bin),
      .err_digit (err_digit),
      .err_range (err_range)
   );

   always #5 clk = ~clk;

   // One comparison: count it, and report tag/observed/expected on mismatch.
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   // Reference model: decimal value by place weights, zero on any bad digit.
   function automatic bit ref_derr(input logic [15:0] b);
      logic [15:0] t;
      t = b;
      for (int i = 0; i < 4; i++) begin
         if (t[4*i +: 4] > 4'd9) return 1'b1;
      end
      return 1'b0;
   endfunction

   function automatic logic [BIN_W-1:0] ref_bin(input logic [15:0] b);
      logic [15:0] t;
      int v;
      t = b;
      if (ref_derr(b)) return '0;
      v = int'(t[3:0]) + 10 * int'(t[7:4]) + 100 * int'(t[11:8]) + 1000 * int'(t[15:12]);
      return BIN_W'(v);
   endfunction

   function automatic bit ref_rerr(input logic [15:0] b, input logic [BIN_W-1:0] l,
                                   input logic [BIN_W-1:0] h);
      if (ref_derr(b)) return 1'b0;
      return (ref_bin(b) < l) || (ref_bin(b) > h);
   endfunction

   // All tasks start and end at #1 after a rising edge.
   task automatic wait_ready();
      int k = 0;
      while (!in_ready && k < 50) begin
         @(posedge clk); #1;
         k++;
      end
      if (!in_ready) chk("ready_timeout", in_ready, 1);
   endtask

   task automatic wait_valid(output int lat);
      lat = 0;
      do begin
         @(posedge clk); #1;
         lat++;
      end while (!out_valid && lat < 20);
      if (!out_valid) chk("valid_timeout", out_valid, 1);
   endtask

   // Full request: accept, check latency and result, optional stall, handshake.
   task automatic do_req(input string name, input logic [15:0] b, input logic [BIN_W-1:0] l,
                         input logic [BIN_W-1:0] h, input int stall);
      int lat;
      logic [BIN_W-1:0] eb;
      bit ed, er;
      eb = ref_bin(b);
      ed = ref_derr(b);
      er = ref_rerr(b, l, h);
      wait_ready();
      bcd = b; lo = l; hi = h; in_valid = 1'b1;
      out_ready = (stall == 0);
      @(posedge clk); #1;
      in_valid = 1'b0;
      bcd = 16'($urandom); lo = 14'($urandom); hi = 14'($urandom);
      wait_valid(lat);
      chk({name, "_latency"}, lat, DIGITS);
      chk({name, "_bin"}, bin, eb);
      chk({name, "_err_digit"}, err_digit, ed);
      chk({name, "_err_range"}, err_range, er);
      chk({name, "_busy"}, in_ready, 0);
      for (int s = 0; s < stall; s++) begin
         @(posedge clk); #1;
         chk({name, "_hold_valid"}, out_valid, 1);
         chk({name, "_hold_bin"}, bin, eb);
      end
      out_ready = 1'b1;
      @(posedge clk); #1;
      chk({name, "_hs_valid"}, out_valid, 0);
      chk({name, "_hs_ready"}, in_ready, 1);
      chk({name, "_kept_bin"}, bin, eb);
      $display("req %-8s bcd=%h lo=%0d hi=%0d -> bin=%0d err_digit=%0b err_range=%0b lat=%0d",
               name, b, l, h, eb, ed, er, lat);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int lat;
      int acc_cyc[$];
      logic [BIN_W-1:0] exp_q[$];
      logic [15:0] vals[4];
      int cyc, nidx, nres;
      bit acc_now, hs_now;

      rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
      bcd = '0; lo = '0; hi = '0;
      #1;
      chk("rst_in_ready", in_ready, 1);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_bin", bin, 0);
      chk("rst_err_digit", err_digit, 0);
      chk("rst_err_range", err_range, 0);
      @(negedge clk); rst_n = 1'b1;
      @(posedge clk); #1;

      // Calendar day window, year range, illegal digit.
      do_req("day31", 16'h0031, 14'd1, 14'd31, 0);
      do_req("day32", 16'h0032, 14'd1, 14'd31, 0);
      do_req("day0", 16'h0000, 14'd1, 14'd31, 0);
      do_req("y9999", 16'h9999, 14'd0, 14'd9999, 0);
      do_req("y2000", 16'h2000, 14'd0, 14'd9999, 0);
      do_req("baddig", 16'h1A05, 14'd1, 14'd31, 0);
      do_req("lo_gt_hi", 16'h0015, 14'd20, 14'd10, 0);

      // Back-pressure: result held, new request ignored until handshake.
      wait_ready();
      out_ready = 1'b0;
      bcd = 16'h0347; lo = 14'd0; hi = 14'd9999; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      wait_valid(lat);
      chk("bp_latency", lat, DIGITS);
      bcd = 16'h0059; lo = 14'd0; hi = 14'd99; in_valid = 1'b1;
      for (int s = 0; s < 10; s++) begin
         @(posedge clk); #1;
         chk("bp_valid", out_valid, 1);
         chk("bp_ready", in_ready, 0);
         chk("bp_bin", bin, 347);
         chk("bp_flags", {err_digit, err_range}, 0);
      end
      out_ready = 1'b1;
      @(posedge clk); #1;
      chk("bp_hs_ready", in_ready, 1);
      chk("bp_hs_valid", out_valid, 0);
      @(posedge clk); #1;
      in_valid = 1'b0;
      chk("bp_accepted", in_ready, 0);
      wait_valid(lat);
      chk("bp59_latency", lat, DIGITS);
      chk("bp59_bin", bin, ref_bin(16'h0059));
      chk("bp59_range", err_range, 0);
      $display("req backpr  bcd=0347 held 10 cycles, then bcd=0059 -> bin=%0d", bin);
      @(posedge clk); #1;

      // Asynchronous reset during the second conversion cycle.
      wait_ready();
      bcd = 16'h0031; lo = 14'd1; hi = 14'd31; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      @(posedge clk); #2;
      rst_n = 1'b0;
      #1;
      chk("mid_rst_in_ready", in_ready, 1);
      chk("mid_rst_out_valid", out_valid, 0);
      chk("mid_rst_bin", bin, 0);
      chk("mid_rst_err", {err_digit, err_range}, 0);
      $display("req midrst  reset asserted during conversion of bcd=0031");
      @(negedge clk); rst_n = 1'b1;
      @(posedge clk); #1;
      chk("post_rst_valid", out_valid, 0);
      do_req("month12", 16'h0012, 14'd1, 14'd12, 0);

      // Back-to-back streaming with both handshakes held high.
      vals[0] = 16'h0023; vals[1] = 16'h0007; vals[2] = 16'h0023; vals[3] = 16'h0007;
      out_ready = 1'b1;
      wait_ready();
      nidx = 0; nres = 0; cyc = 0;
      bcd = vals[0]; lo = 14'd0; hi = 14'd59; in_valid = 1'b1;
      while (nres < 4 && cyc < 80) begin
         acc_now = in_valid && in_ready;
         hs_now  = out_valid && out_ready;
         if (hs_now) begin
            if (exp_q.size() > 0) chk("b2b_bin", bin, exp_q.pop_front());
            else chk("b2b_spurious", 1, 0);
            nres++;
         end
         @(posedge clk); #1;
         cyc++;
         if (acc_now) begin
            acc_cyc.push_back(cyc);
            exp_q.push_back(ref_bin(vals[nidx]));
            nidx++;
            if (nidx == 4) in_valid = 1'b0;
            else bcd = vals[nidx];
         end
      end
      chk("b2b_results", nres, 4);
      for (int i = 1; i < acc_cyc.size(); i++) begin
         chk("b2b_accept_gap", acc_cyc[i] - acc_cyc[i-1], DIGITS + 2);
         $display("req b2b     accept gap %0d = %0d cycles", i, acc_cyc[i] - acc_cyc[i-1]);
      end
      wait_ready();

      // Randomized requests against the reference model.
      for (int r = 0; r < 24; r++) begin
         logic [15:0] rb;
         logic [BIN_W-1:0] rl, rh;
         for (int d = 0; d < 4; d++) begin
            if ($urandom_range(0, 7) == 0) rb[4*d +: 4] = 4'($urandom_range(10, 15));
            else rb[4*d +: 4] = 4'($urandom_range(0, 9));
         end
         rl = 14'($urandom_range(0, 9999));
         rh = 14'($urandom_range(0, 9999));
         if ($urandom_range(0, 1) == 1) begin
            rl = 14'd0; rh = 14'd9999;
         end
         do_req("random", rb, rl, rh, $urandom_range(0, 3));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
